cache_victim_ctrl: RTL
======================

CACHE_VICTIM_CTRL -- requirements
Module: cache_victim_ctrl

Interface
REQ-001 The block SHALL have parameter INDEX_W, default 6, meaning set-index width (2**INDEX_W sets, 2 ways).
REQ-002 The block SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-003 The block SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have ports req_valid/req_ready  input/output  1/1  lookup-result handshake; transfer when both are high.
REQ-005 The block SHALL have ports req_index  input  INDEX_W, req_hit  input  1, req_hit_way  input  2 (one-hot), req_store  input  1 (access is a store).
REQ-006 The block SHALL have ports resp_valid  output  1 (one-cycle completion pulse) and resp_way  output  2 (one-hot way used).
REQ-007 The block SHALL have ports wb_valid  output  1, wb_ready  input  1, wb_index  output  INDEX_W, wb_way  output  2, and wb_done  input  1 (writeback finished).
REQ-008 The block SHALL have ports rf_valid  output  1, rf_ready  input  1, rf_index  output  INDEX_W, rf_way  output  2, and rf_done  input  1 (refill finished).

Function
REQ-009 The block SHALL hold per-set state valid[1:0], dirty[1:0] and lru (1 = way0 least recent).
REQ-010 The FSM SHALL have states IDLE, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, DONE; req_ready SHALL be 1 only in IDLE.
REQ-011 On a hit transfer: lru[set] <= 0 if way0 hit, 1 if way1 hit; dirty[set][way] |= req_store; FSM -> DONE; resp_way = hit way.
REQ-012 If req_hit_way == 2'b11, way0 SHALL take priority; a hit with req_hit_way == 2'b00 SHALL be handled as a miss.
REQ-013 On a miss transfer, the victim SHALL be latched with index: valid 00 -> way1; 01 -> way1; 10 -> way0; 11 -> way0 if lru == 1, else way1.
REQ-014 After a miss, the FSM SHALL go to WB_REQ if the victim is valid and dirty, else to RF_REQ.
REQ-015 In WB_REQ: wb_valid = 1, holding index/way stable until wb_ready; then -> WB_WAIT.
REQ-016 In WB_WAIT: on wb_done -> RF_REQ; wb_done SHALL be ignored in all other states.
REQ-017 In RF_REQ: rf_valid = 1, holding index/way stable until rf_ready; then -> RF_WAIT.
REQ-018 In RF_WAIT: on rf_done, set valid[way] = 1 and dirty[way] = req_store, update lru as in REQ-011, then -> DONE.
REQ-019 In DONE: resp_valid = 1 for exactly one cycle, then -> IDLE.
REQ-020 Latency SHALL be: hit, resp_valid 1 cycle after transfer; clean miss with zero-wait ready/done, resp_valid 3 cycles after transfer.
REQ-021 Table updates SHALL occur only in the cycles named above; other sets SHALL be unchanged.

Reset
REQ-022 On resetn low, the block SHALL immediately, including mid-operation, clear all valid, dirty and lru bits and force the FSM to IDLE.
REQ-023 During reset: req_ready, resp_valid, wb_valid and rf_valid = 0; resp_way/wb_way/rf_way = 2'b00; wb_index/rf_index = 0.
REQ-024 An in-flight miss SHALL be abandoned by reset, with no table update.
REQ-025 After reset release, req_ready SHALL be 1 on the first clock edge.

Configuration
REQ-026 With CACHE_VICTIM_RAND_EN defined, the both-valid victim SHALL be lfsr[0] ? way1 : way0.
REQ-027 The 3-bit lfsr SHALL reset to 3'b001 and advance on each miss transfer as {l[0]^l[1], l[2:1]}; lru SHALL still be updated.
REQ-028 Without CACHE_VICTIM_RAND_EN, there SHALL be no lfsr and the both-valid victim SHALL be selected by lru (REQ-013).

Verification
REQ-029 Scenario: after reset, miss at set 5 -> rf_valid, rf_index = 5, rf_way = 2'b10, no wb_valid; after rf_done, resp_way = 2'b10.
REQ-030 Scenario: fill set 3 both ways with loads, then hit way1 -> next miss at set 3 selects way0 (LRU build).
REQ-031 Scenario: store-miss fills way1 of set 7, then way0, then hit way0, then miss -> wb_valid with wb_way = 2'b10 before rf_valid; wb_ready held low 4 cycles keeps wb_* stable.
REQ-032 Scenario: hit with req_hit_way = 2'b11 -> resp_way = 2'b01 one cycle later, and lru[set] = 0.
REQ-033 Scenario: resetn asserted in RF_WAIT -> all valid outputs low immediately; same set later misses to way1 with no writeback.
REQ-034 Scenario (RAND_EN): four consecutive both-valid misses -> victims follow lfsr[0] sequence 1,0,0,1 (way1, way0, way0, way1).

Source files
------------

// File: rtl/cache_victim_ctrl_if.sv
// Bundles the lookup request/response, writeback and refill channels of the victim controller.
// The controller attaches through the slave modport and its environment through master.
interface cache_victim_ctrl_if #(
    parameter int unsigned INDEX_W = 6
);
    logic               req_valid;
    logic               req_ready;
    logic [INDEX_W-1:0] req_index;
    logic               req_hit;
    logic [1:0]         req_hit_way;
    logic               req_store;
    logic               resp_valid;
    logic [1:0]         resp_way;
    logic               wb_valid;
    logic               wb_ready;
    logic [INDEX_W-1:0] wb_index;
    logic [1:0]         wb_way;
    logic               wb_done;
    logic               rf_valid;
    logic               rf_ready;
    logic [INDEX_W-1:0] rf_index;
    logic [1:0]         rf_way;
    logic               rf_done;

    modport slave (
        input  req_valid, req_index, req_hit, req_hit_way, req_store,
        input  wb_ready, wb_done, rf_ready, rf_done,
        output req_ready, resp_valid, resp_way,
        output wb_valid, wb_index, wb_way, rf_valid, rf_index, rf_way
    );

    modport master (
        output req_valid, req_index, req_hit, req_hit_way, req_store,
        output wb_ready, wb_done, rf_ready, rf_done,
        input  req_ready, resp_valid, resp_way,
        input  wb_valid, wb_index, wb_way, rf_valid, rf_index, rf_way
    );
endinterface

// File: rtl/cache_victim_ctrl.sv
// Two-way set-associative victim selection, writeback and refill sequencing controller.
// Define CACHE_VICTIM_RAND_EN to pick the both-valid victim from a 3-bit LFSR instead of LRU.
module cache_victim_ctrl #(
    parameter int unsigned INDEX_W = 6
) (
    input logic                 clock,
    input logic                 resetn,
    cache_victim_ctrl_if.slave  bus
);
    localparam int unsigned Sets = 1 << INDEX_W;

    typedef enum logic [2:0] {StIdle, StWbReq, StWbWait, StRfReq, StRfWait, StDone} state_e;

    state_e             state_q, state_d;
    logic [INDEX_W-1:0] idx_q, idx_d;
    logic [1:0]         way_q, way_d;
    logic               store_q, store_d;
    logic               init_q;

    logic [1:0]      valid_q [Sets];
    logic [1:0]      dirty_q [Sets];
    logic [Sets-1:0] lru_q;

    logic       xfer, is_hit, hit_upd, fill_upd, miss_xfer, victim_dirty;
    logic [1:0] hit_way, victim, set_valid, set_dirty;

`ifdef CACHE_VICTIM_RAND_EN
    logic [2:0] lfsr_q;
`endif

    assign set_valid = valid_q[bus.req_index];
    assign set_dirty = dirty_q[bus.req_index];
    assign hit_way   = bus.req_hit_way[0] ? 2'b01 : (bus.req_hit_way[1] ? 2'b10 : 2'b00);
    assign is_hit    = bus.req_hit && (bus.req_hit_way != 2'b00);
    assign xfer      = bus.req_valid && bus.req_ready;

    always_comb begin
        victim = 2'b10;
        unique case (set_valid)
            2'b00, 2'b01: victim = 2'b10;
            2'b10:        victim = 2'b01;
            default: begin
`ifdef CACHE_VICTIM_RAND_EN
                victim = lfsr_q[0] ? 2'b10 : 2'b01;
`else
                victim = lru_q[bus.req_index] ? 2'b01 : 2'b10;
`endif
            end
        endcase
    end

    assign victim_dirty = |(victim & set_valid & set_dirty);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        way_d     = way_q;
        store_d   = store_q;
        hit_upd   = 1'b0;
        fill_upd  = 1'b0;
        miss_xfer = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    idx_d   = bus.req_index;
                    store_d = bus.req_store;
                    if (is_hit) begin
                        way_d   = hit_way;
                        hit_upd = 1'b1;
                        state_d = StDone;
                    end else begin
                        way_d     = victim;
                        miss_xfer = 1'b1;
                        state_d   = victim_dirty ? StWbReq : StRfReq;
                    end
                end
            end
            StWbReq:  if (bus.wb_ready) state_d = StWbWait;
            StWbWait: if (bus.wb_done) state_d = StRfReq;
            StRfReq:  if (bus.rf_ready) state_d = StRfWait;
            StRfWait: begin
                if (bus.rf_done) begin
                    fill_upd = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // init_q holds req_ready low while reset is asserted, rising on the first edge after release.
    assign bus.req_ready  = (state_q == StIdle) && init_q;
    assign bus.resp_valid = (state_q == StDone);
    assign bus.resp_way   = (state_q == StDone) ? way_q : 2'b00;
    assign bus.wb_valid   = (state_q == StWbReq);
    assign bus.wb_index   = (state_q == StWbReq) ? idx_q : '0;
    assign bus.wb_way     = (state_q == StWbReq) ? way_q : 2'b00;
    assign bus.rf_valid   = (state_q == StRfReq);
    assign bus.rf_index   = (state_q == StRfReq) ? idx_q : '0;
    assign bus.rf_way     = (state_q == StRfReq) ? way_q : 2'b00;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            idx_q   <= '0;
            way_q   <= 2'b00;
            store_q <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            way_q   <= way_d;
            store_q <= store_d;
            init_q  <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < Sets; i++) begin
                valid_q[i] <= 2'b00;
                dirty_q[i] <= 2'b00;
            end
            lru_q <= '0;
        end else if (hit_upd) begin
            lru_q[bus.req_index]   <= hit_way[1];
            dirty_q[bus.req_index] <= set_dirty | (hit_way & {2{bus.req_store}});
        end else if (fill_upd) begin
            valid_q[idx_q] <= valid_q[idx_q] | way_q;
            dirty_q[idx_q] <= (dirty_q[idx_q] & ~way_q) | (way_q & {2{store_q}});
            lru_q[idx_q]   <= way_q[1];
        end
    end

`ifdef CACHE_VICTIM_RAND_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= 3'b001;
        end else if (miss_xfer) begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[1], lfsr_q[2:1]};
        end
    end
`endif
endmodule
